mem_ctrl: RTL and testbench



---
 rtl/mem_ctrl_if.sv | 41 ++++
 rtl/mem_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_if
// Description : Request/response handshake between a requester (datapath or
//               fetch unit) and the memory-interface controller.
//               master modport : requester side
//               slave  modport : controller side
//   req_valid  request present                (master -> slave)
//   req_ready  controller can accept          (slave  -> master)
//   req_we     1 = store, 0 = load            (master -> slave)
//   req_addr   word address                   (master -> slave)
//   req_wdata  store data                     (master -> slave)
//   rsp_valid  one-cycle response pulse       (slave  -> master)
//   rsp_rdata  load data                      (slave  -> master)
//   rsp_err    address out of range           (slave  -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_wdata;
  logic              rsp_valid;
  logic [DWIDTH-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl
// Description : Single-outstanding memory-interface controller in front of a
//               shared-bus RAM. Accepts one load/store at a time, drives the
//               RAM address/strobes, owns the Data bus only while storing,
//               waits out the RAM access time on loads and returns exactly
//               one response per request. Out-of-range addresses are answered
//               with an error and never reach the RAM.
// Ports       :
//   clk       in     system clock, rising edge
//   rst       in     synchronous active-high reset
//   bus       slave  request/response handshake (mem_ctrl_if)
//   mem_Addr  out    RAM word address
//   mem_rdEn  out    RAM store strobe (1 = controller drives Data)
//   mem_wrEn  out    write indicator, mirrors mem_rdEn
//   mem_Data  inout  shared tri-state data bus
// Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl #(
  parameter int DWIDTH      = 32,
  parameter int ADEPTH      = 1000,
  parameter int AWIDTH      = $clog2(ADEPTH),
  parameter int WAIT_CYCLES = 5
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic [AWIDTH-1:0] mem_Addr,
  output logic              mem_rdEn,
  output logic              mem_wrEn,
  inout  wire  [DWIDTH-1:0] mem_Data
);

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_store = 2'd1;
  localparam logic [1:0] c_load  = 2'd2;
  localparam logic [1:0] c_resp  = 2'd3;

  // Counter preload: LOAD lasts WAIT_CYCLES cycles, sampling when it hits 0.
  localparam logic [7:0] c_cnt_init = 8'(WAIT_CYCLES - 1);

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [AWIDTH-1:0] r_addr;
  logic [DWIDTH-1:0] r_wdata;
  logic [7:0]        r_cnt;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_err;
  logic              w_addr_bad;
  logic              w_drive;

  // Zero-extend to 32 bits so ADEPTH itself is representable in the compare.
  assign w_addr_bad = (32'(bus.req_addr) >= 32'(ADEPTH));

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle: begin
        // req_ready is 1 throughout IDLE, so valid alone means acceptance.
        if (bus.req_valid) begin
          if (w_addr_bad) begin
            w_state_next = c_resp;
          end else if (bus.req_we) begin
            w_state_next = c_store;
          end else begin
            w_state_next = c_load;
          end
        end
      end
      c_store: w_state_next = c_resp;
      c_load:  if (r_cnt == 8'd0) w_state_next = c_resp;
      c_resp:  w_state_next = c_idle;
      default: w_state_next = c_idle;
    endcase
  end

  // ----------------------------------------------------------------- outputs
  // Strobes decode straight from the state register, so a reset sampled
  // during STORE drops them in the very next cycle.
  always_comb begin
    bus.req_ready = (r_state == c_idle);
    bus.rsp_valid = (r_state == c_resp);
    w_drive       = (r_state == c_store);
    mem_rdEn      = w_drive;
    mem_wrEn      = w_drive;
  end

  assign mem_Data      = w_drive ? r_wdata : {DWIDTH{1'bz}};
  assign mem_Addr      = r_addr;
  assign bus.rsp_rdata = r_rdata;
  assign bus.rsp_err   = r_err;

  // ---------------------------------------------------------------- datapath
  // rsp_err/rsp_rdata are updated only on the edge entering RESP so they hold
  // their value until the next response; rdata changes on loads only.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.req_valid) begin
            if (w_addr_bad) begin
              r_err <= 1'b1;
            end else begin
              r_addr  <= bus.req_addr;
              r_wdata <= bus.req_wdata;
              if (!bus.req_we) r_cnt <= c_cnt_init;
            end
          end
        end
        c_store: r_err <= 1'b0;
        c_load: begin
          if (r_cnt == 8'd0) begin
            r_rdata <= mem_Data;
            r_err   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_ctrl
// Description : Directed self-checking bench for mem_ctrl with a behavioural
//               shared-bus RAM (captures on rising edge while mem_rdEn=1,
//               drives Data whenever mem_rdEn=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;
  localparam int DW = 32;
  localparam int AD = 1000;
  localparam int AW = 10;
  localparam int WC = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  logic [AW-1:0] mem_Addr;
  logic          mem_rdEn;
  logic          mem_wrEn;
  wire  [DW-1:0] mem_Data;

  mem_ctrl #(.DWIDTH(DW), .ADEPTH(AD), .AWIDTH(AW), .WAIT_CYCLES(WC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .mem_Addr (mem_Addr),
    .mem_rdEn (mem_rdEn),
    .mem_wrEn (mem_wrEn),
    .mem_Data (mem_Data)
  );

  // RAM model with a backdoor preload port
  logic [DW-1:0] ram [0:1023];
  logic          pl_we   = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  always @(posedge clk) begin
    if (mem_rdEn) ram[mem_Addr] <= mem_Data;
    else if (pl_we) ram[pl_addr] <= pl_data;
  end
  assign mem_Data = mem_rdEn ? {DW{1'bz}} : ram[mem_Addr];

  int vectors = 0;
  int miscompares = 0;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  // Presents a request and returns just after its acceptance edge.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input bit hold, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wd;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.req_ready === 1'b1);
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
  endtask

  // Counts cycles from acceptance to rsp_valid and records bus activity.
  task automatic wait_rsp(output int lat, output int rd_cyc, output int rdy_cyc,
                          output bit addr_moved, output bit wr_mis,
                          output logic [DW-1:0] rdata, output logic err);
    logic [AW-1:0] a0;
    a0 = mem_Addr;
    lat = 0; rd_cyc = 0; rdy_cyc = 0; addr_moved = 1'b0; wr_mis = 1'b0;
    rdata = '0; err = 1'b0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (mem_rdEn === 1'b1) rd_cyc++;
      if (mem_wrEn !== mem_rdEn) wr_mis = 1'b1;
      if (bus.req_ready === 1'b1) rdy_cyc++;
      if (mem_Addr !== a0) addr_moved = 1'b1;
      if (bus.rsp_valid === 1'b1) begin
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 10'd5; bus.req_wdata = 32'hDEADBEEF;
    repeat (2) begin
      @(negedge clk);
      vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", bus.req_ready); end
      vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
      vectors++; if (mem_rdEn !== 1'b0) begin miscompares++; $display("FAIL reset_rdEn got=%b exp=0", mem_rdEn); end
      vectors++; if (mem_wrEn !== 1'b0) begin miscompares++; $display("FAIL reset_wrEn got=%b exp=0", mem_wrEn); end
      vectors++; if (mem_Addr !== 10'd0) begin miscompares++; $display("FAIL reset_addr got=%0d exp=0", mem_Addr); end
      vectors++; if (mem_Data !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL reset_bus_released got=%h exp=5a5a5a5a", mem_Data); end
      vectors++; if (bus.rsp_err !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", bus.rsp_err); end
      vectors++; if (bus.rsp_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h exp=0", bus.rsp_rdata); end
    end
    rst = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_idle got=%b exp=1", bus.req_ready); end
    vectors++; if (mem_rdEn !== 1'b0) begin miscompares++; $display("FAIL post_reset_rdEn got=%b exp=0", mem_rdEn); end
    vectors++; if (ram[5] !== 32'h0) begin miscompares++; $display("FAIL reset_no_accept ram5 got=%h exp=0", ram[5]); end
  endtask

  task automatic test_store_load;
    bit ok; int lat, rd, rdy; bit mv, wm; logic [DW-1:0] rd_d; logic er;
    issue(1'b1, 10'd107, 32'h0000000D, 1'b0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL st_accept got=0 exp=1"); end
    wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
    vectors++; if (lat !== 2) begin miscompares++; $display("FAIL st_latency got=%0d exp=2", lat); end
    vectors++; if (rd !== 1) begin miscompares++; $display("FAIL st_strobe_cycles got=%0d exp=1", rd); end
    vectors++; if (wm !== 1'b0) begin miscompares++; $display("FAIL st_wrEn_mirror got=%b exp=0", wm); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL st_err got=%b exp=0", er); end
    vectors++; if (rd_d !== 32'h0) begin miscompares++; $display("FAIL st_rdata_held got=%h exp=0", rd_d); end
    vectors++; if (ram[107] !== 32'h0000000D) begin miscompares++; $display("FAIL st_ram107 got=%h exp=d", ram[107]); end

    issue(1'b0, 10'd107, 32'h0, 1'b0, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL ld_accept got=0 exp=1"); end
    wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
    vectors++; if (lat !== WC + 1) begin miscompares++; $display("FAIL ld_latency got=%0d exp=%0d", lat, WC + 1); end
    vectors++; if (rd_d !== 32'h0000000D) begin miscompares++; $display("FAIL ld_rdata got=%h exp=d", rd_d); end
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL ld_err got=%b exp=0", er); end
    vectors++; if (rd !== 0) begin miscompares++; $display("FAIL ld_strobe got=%0d exp=0", rd); end
  endtask

  task automatic test_preload_fetch;
    bit ok; int lat, rd, rdy; bit mv, wm; logic [DW-1:0] rd_d; logic er;
    issue(1'b0, 10'd100, 32'h0, 1'b0, ok);
    vectors++; if (mem_Addr !== 10'd100) begin miscompares++; $display("FAIL pf_addr got=%0d exp=100", mem_Addr); end
    wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
    vectors++; if (rd_d !== 32'hC0000001) begin miscompares++; $display("FAIL pf_rdata got=%h exp=c0000001", rd_d); end
    vectors++; if (mv !== 1'b0) begin miscompares++; $display("FAIL pf_addr_stable got=%b exp=0", mv); end
    vectors++; if (rd !== 0) begin miscompares++; $display("FAIL pf_bus_driven got=%0d exp=0", rd); end
    vectors++; if (lat !== 6) begin miscompares++; $display("FAIL pf_latency got=%0d exp=6", lat); end
  endtask

  task automatic test_bounds;
    bit ok; int lat, rd, rdy; bit mv, wm; logic [DW-1:0] rd_d; logic er;
    issue(1'b0, 10'd999, 32'h0, 1'b0, ok);
    wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
    vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL bnd999_err got=%b exp=0", er); end
    vectors++; if (rd_d !== 32'h000003E7) begin miscompares++; $display("FAIL bnd999_rdata got=%h exp=3e7", rd_d); end

    issue(1'b1, 10'd1000, 32'h00000BAD, 1'b0, ok);
    wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL bnd1000_latency got=%0d exp=1", lat); end
    vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL bnd1000_err got=%b exp=1", er); end
    vectors++; if (rd !== 0) begin miscompares++; $display("FAIL bnd1000_strobe got=%0d exp=0", rd); end
    vectors++; if (mem_Addr !== 10'd999) begin miscompares++; $display("FAIL bnd1000_addr_kept got=%0d exp=999", mem_Addr); end
    vectors++; if (rd_d !== 32'h000003E7) begin miscompares++; $display("FAIL bnd1000_rdata_held got=%h exp=3e7", rd_d); end
    vectors++; if (ram[999] !== 32'h000003E7) begin miscompares++; $display("FAIL bnd1000_ram999 got=%h exp=3e7", ram[999]); end
  endtask

  task automatic test_back_to_back;
    bit ok; int lat, rd, rdy, extra; bit mv, wm; logic [DW-1:0] rd_d; logic er;
    logic          we_v [4];
    logic [AW-1:0] ad_v [4];
    logic [DW-1:0] wd_v [4];
    we_v = '{1'b1, 1'b1, 1'b1, 1'b0};
    ad_v = '{10'd200, 10'd201, 10'd202, 10'd202};
    wd_v = '{32'h11, 32'h22, 32'h33, 32'h0};
    for (int i = 0; i < 4; i++) begin
      issue(we_v[i], ad_v[i], wd_v[i], 1'b1, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_accept[%0d] got=0 exp=1", i); end
      wait_rsp(lat, rd, rdy, mv, wm, rd_d, er);
      if (i == 3) bus.req_valid = 1'b0;
      vectors++; if (lat !== (we_v[i] ? 2 : WC + 1)) begin miscompares++; $display("FAIL b2b_latency[%0d] got=%0d exp=%0d", i, lat, we_v[i] ? 2 : WC + 1); end
      vectors++; if (rdy !== 0) begin miscompares++; $display("FAIL b2b_ready_low[%0d] got=%0d exp=0", i, rdy); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL b2b_err[%0d] got=%b exp=0", i, er); end
    end
    vectors++; if (rd_d !== 32'h33) begin miscompares++; $display("FAIL b2b_final_rdata got=%h exp=33", rd_d); end
    vectors++; if (ram[201] !== 32'h22) begin miscompares++; $display("FAIL b2b_ram201 got=%h exp=22", ram[201]); end
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL b2b_extra_rsp got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid;
    bit ok; int extra;
    // reset during the 3rd LOAD cycle
    issue(1'b0, 10'd100, 32'h0, 1'b0, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rml_idle got=%b exp=1", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rml_rsp got=%b exp=0", bus.rsp_valid); end
    vectors++; if (mem_rdEn !== 1'b0) begin miscompares++; $display("FAIL rml_rdEn got=%b exp=0", mem_rdEn); end
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL rml_no_rsp got=%0d exp=0", extra); end

    // reset coincident with STORE
    issue(1'b1, 10'd300, 32'h77, 1'b0, ok);
    @(negedge clk);
    vectors++; if (mem_rdEn !== 1'b1) begin miscompares++; $display("FAIL rms_in_store got=%b exp=1", mem_rdEn); end
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (mem_rdEn !== 1'b0) begin miscompares++; $display("FAIL rms_rdEn got=%b exp=0", mem_rdEn); end
    vectors++; if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rms_idle got=%b exp=1", bus.req_ready); end
    vectors++; if (bus.rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rms_rsp got=%b exp=0", bus.rsp_valid); end
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) extra++;
    end
    vectors++; if (extra !== 0) begin miscompares++; $display("FAIL rms_no_rsp got=%0d exp=0", extra); end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    preload(10'd0,   32'h5A5A5A5A);
    preload(10'd5,   32'h00000000);
    preload(10'd100, 32'hC0000001);
    preload(10'd999, 32'h000003E7);
    test_reset();
    test_store_load();
    test_preload_fetch();
    test_bounds();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
